tamper_event_logger: RTL and testbench

Fabric-side consumer of the SmartFusion2 tamper macro wrapper outputs. It synchronizes the tamper change strobe and captures each tamper event (flags plus category) into a small FIFO that the MSS/firmware side drains over a valid/ready port. It keeps a saturating event counter and a sticky overflow flag. After a programmable number of failed detections it issues a timed active-low reset pulse to the tamper macro's RESET_N input, closing the loop with the wrapper.

---
 rtl/tamper_event_logger.sv | 147 ++++++++++++++
 tb/tb_tamper_event_logger.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tamper_event_logger.sv
// Fabric-side tamper event logger: synchronizes the tamper strobe and flags, queues events
// for firmware, counts them, and pulses the tamper macro reset after repeated detect failures.
module tamper_event_logger #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int FAIL_THRESH = 4,
  parameter int PULSE_LEN   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TAMPER_CHANGE_STROBE,
  input  logic             DETECT_ATTEMPT,
  input  logic             DETECT_FAIL,
  input  logic             DIGEST_ERROR,
  input  logic             MESH_SHORT_ERROR,
  input  logic [3:0]       DETECT_CATEGORY,
  output logic             EVT_VALID,
  output logic [7:0]       EVT_DATA,
  input  logic             EVT_READY,
  output logic [CNT_W-1:0] EVT_COUNT,
  output logic             OVERFLOW,
  input  logic             CLR_STATUS,
  output logic             RESP_RESET_N
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

  // strb_q = {s3, s2, s1}
  logic [2:0]       strb_q;
  logic [7:0]       din_s1_q, din_s2_q;
  logic             evt, fail_evt;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, push, pop, drop;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       fail_q, fail_d;

  state_t           state_q, state_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             resp_n_q, resp_n_d;

  assign evt      = strb_q[1] & ~strb_q[2];
  assign fail_evt = evt & din_s2_q[6];

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop  = valid_q & EVT_READY;
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  // Head register looks ahead to the post-edge head so pops sustain one entry per clock;
  // a slot being written this edge is forwarded straight from the synchronizer.
  always_comb begin
    valid_d = (rd_ptr_d != wr_ptr_d);
    data_d  = data_q;
    if (valid_d) begin
      if (rd_ptr_d == wr_ptr_q) data_d = din_s2_q;
      else                      data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (CLR_STATUS)                  cnt_d = evt ? CNT_W'(1) : '0;
    else if (evt && (cnt_q != '1))   cnt_d = cnt_q + CNT_W'(1);

    ovf_d = (CLR_STATUS ? 1'b0 : ovf_q) | drop;

    fail_d = fail_q;
    if (CLR_STATUS)                                 fail_d = fail_evt ? 8'd1 : 8'd0;
    else if (fail_evt && (fail_q < 8'(FAIL_THRESH))) fail_d = fail_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE: begin
        if (fail_q == 8'(FAIL_THRESH)) begin
          state_d = PULSE;
          pcnt_d  = 8'(PULSE_LEN - 1);
        end
      end
      PULSE: begin
        if (pcnt_q == 8'd0) state_d = HOLDOFF;
        else                pcnt_d  = pcnt_q - 8'd1;
      end
      HOLDOFF: begin
        if (CLR_STATUS) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_n_d = (state_d != PULSE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      strb_q   <= '0;
      din_s1_q <= '0;
      din_s2_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fail_q   <= '0;
      state_q  <= IDLE;
      pcnt_q   <= '0;
      resp_n_q <= 1'b1;
    end else begin
      strb_q   <= {strb_q[1:0], TAMPER_CHANGE_STROBE};
      din_s1_q <= {DETECT_ATTEMPT, DETECT_FAIL, DIGEST_ERROR, MESH_SHORT_ERROR, DETECT_CATEGORY};
      din_s2_q <= din_s1_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fail_q   <= fail_d;
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      resp_n_q <= resp_n_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din_s2_q;
  end

  assign EVT_VALID    = valid_q;
  assign EVT_DATA     = data_q;
  assign EVT_COUNT    = cnt_q;
  assign OVERFLOW     = ovf_q;
  assign RESP_RESET_N = resp_n_q;

endmodule

// File: tb/tb_tamper_event_logger.sv
// Scoreboard bench for tamper_event_logger: expected FIFO entries are queued as events are
// driven and compared as the consumer drains them.
module tb_tamper_event_logger;

  logic       clk = 1'b0;
  logic       rst, strobe, attempt, dfail, digest, mesh, ready, clr;
  logic [3:0] cat;
  logic       valid, ovf, resp;
  logic [7:0] data;
  logic [3:0] count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         exp_count = 0;
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  tamper_event_logger #(
    .FIFO_DEPTH(8), .CNT_W(4), .FAIL_THRESH(4), .PULSE_LEN(16)
  ) dut (
    .CLK(clk), .RESET(rst), .TAMPER_CHANGE_STROBE(strobe),
    .DETECT_ATTEMPT(attempt), .DETECT_FAIL(dfail), .DIGEST_ERROR(digest),
    .MESH_SHORT_ERROR(mesh), .DETECT_CATEGORY(cat),
    .EVT_VALID(valid), .EVT_DATA(data), .EVT_READY(ready),
    .EVT_COUNT(count), .OVERFLOW(ovf), .CLR_STATUS(clr), .RESP_RESET_N(resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic set_in(input logic [7:0] d);
    {attempt, dfail, digest, mesh, cat} = d;
  endtask

  task automatic model_push(input logic [7:0] d);
    exp_count = (exp_count == 15) ? 15 : exp_count + 1;
    if (sb.size() < 8) sb.push_back(d);
    else               exp_ovf = 1'b1;
  endtask

  task automatic send_event(input logic [7:0] d);
    set_in(d);
    strobe = 1'b1;
    repeat (2) @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
    model_push(d);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_ovf"},   32'(ovf),   32'(exp_ovf));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_count = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [7:0] exp;
    ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      check({tag, "_valid"}, 32'(valid), 32'd1);
      exp = sb.pop_front();
      check({tag, "_data"}, 32'(data), 32'(exp));
      @(negedge clk);
    end
    ready = 1'b0;
    check({tag, "_left"},  32'(sb.size()), 32'd0);
    check({tag, "_empty"}, 32'(valid), 32'd0);
  endtask

  // Three fail events, then a fourth with the pulse timed relative to its FIFO write.
  task automatic fail_pulse(input string tag, input bit do_clr);
    int lowcnt;
    for (int i = 0; i < 3; i++) send_event(8'h40 | 8'(i));
    set_in(8'h4F);
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    model_push(8'h4F);
    check({tag, "_resp_pre"}, 32'(resp), 32'd1);
    @(negedge clk);
    check({tag, "_resp_start"}, 32'(resp), 32'd0);
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp) break;
      lowcnt++;
      if (do_clr && i == 5) clr = 1'b1;
      if (do_clr && i == 6) begin
        clr = 1'b0;
        exp_count = 0;
        exp_ovf   = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_pulse_len"}, 32'(lowcnt), 32'd16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lowcnt;
    logic [7:0] d;
    rst = 1'b1; strobe = 1'b0; ready = 1'b0; clr = 1'b0;
    set_in(8'h00);
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_resp",  32'(resp),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single event, strobe held high 5 clocks, first sample at the next posedge (k).
    set_in(8'h8A);
    strobe = 1'b1;
    @(negedge clk);
    check("single_valid_k", 32'(valid), 32'd0);
    @(negedge clk);
    check("single_valid_k1", 32'(valid), 32'd0);
    @(negedge clk);
    check("single_valid_k2", 32'(valid), 32'd1);
    check("single_data", 32'(data), 32'h8A);
    repeat (2) @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    model_push(8'h8A);
    check_status("single");
    drain("single");

    // Overflow: nine events into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) send_event(8'($urandom) & 8'hBF);
    check_status("ovf");
    drain("ovf");
    pulse_clr();
    check_status("ovf_clr");

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 8; i++) send_event(8'($urandom) & 8'hBF);
    check_status("full");
    d = 8'h35;
    set_in(d);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    check("full_head", 32'(data), 32'(sb[0]));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    void'(sb.pop_front());
    model_push(d);
    repeat (2) @(negedge clk);
    check_status("pushpop");
    drain("pushpop");
    pulse_clr();

    // Response pulse, no retrigger from HOLDOFF, then re-arm with CLR and a mid-pulse clear.
    fail_pulse("resp1", 1'b0);
    send_event(8'h42);
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!resp) lowcnt++;
      @(negedge clk);
    end
    check("resp_no_retrigger", 32'(lowcnt), 32'd0);
    check_status("resp1");
    drain("resp1");
    pulse_clr();
    fail_pulse("resp2", 1'b1);
    check_status("resp2");
    drain("resp2");

    // Count saturation, then CLR coincident with an event.
    pulse_clr();
    for (int i = 0; i < 20; i++) send_event(8'($urandom) & 8'hBF);
    check_status("sat");
    drain("sat");
    d = 8'h1C;
    set_in(d);
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    strobe = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_count = 1;
    exp_ovf   = 1'b0;
    sb.push_back(d);
    repeat (2) @(negedge clk);
    check_status("clr_evt");
    drain("clr_evt");

    // Asynchronous reset in the middle of a pulse with the FIFO occupied.
    pulse_clr();
    for (int i = 0; i < 4; i++) send_event(8'h40 | 8'(i));
    repeat (3) @(negedge clk);
    check("mid_resp_low", 32'(resp), 32'd0);
    check("mid_valid", 32'(valid), 32'd1);
    set_in(8'h41);
    strobe = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_data",  32'(data),  32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovf",   32'(ovf),   32'd0);
    check("arst_resp",  32'(resp),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_count = 0;
    exp_ovf   = 1'b0;
    repeat (6) @(negedge clk);
    strobe = 1'b0;
    model_push(8'h41);
    repeat (3) @(negedge clk);
    check_status("release");
    drain("release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
